// File: rtl/bus_srv_pkg.sv
// Shared types and defaults for the bus seat booking server.
// Holds the FSM state encoding and the default sizing constants.
package bus_srv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int NUM_SEATS_D   = 32;
  localparam int HOLD_CYCLES_D = 16;
  localparam int TICKET_W_D    = 8;

endpackage

// File: rtl/hold_timer.sv
// Down-counter for the payment hold window.
// Ports: clk, rst (sync, active-high), load/load_val, dec -> count, last.
module hold_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/bus_seat_server.sv
// Seat booking server: check request, hold seat, ticket/cancel/timeout.
// Ports: clk, rst, req_*, pay_valid, cancel -> grant, reject, ticket_*, timeout, seats_free.
module bus_seat_server
  import bus_srv_pkg::*;
#(
  parameter int NUM_SEATS   = NUM_SEATS_D,
  parameter int SEAT_W      = 6,
  parameter int HOLD_CYCLES = HOLD_CYCLES_D,
  parameter int TICKET_W    = TICKET_W_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [SEAT_W-1:0]   req_seat,
  output logic                req_ready,
  input  logic                pay_valid,
  input  logic                cancel,
  output logic                grant,
  output logic                reject,
  output logic                ticket_valid,
  output logic [TICKET_W-1:0] ticket_id,
  output logic                timeout,
  output logic [SEAT_W:0]     seats_free
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SEAT_W:0] NS = (SEAT_W + 1)'(NUM_SEATS);

  state_t state;
  state_t state_next;

  logic [SEAT_W-1:0]      seat_q;
  // Sized to the full index space so any seat_q indexes safely;
  // entries at or above NUM_SEATS are never set.
  logic [2**SEAT_W-1:0]   booked;
  logic [TICKET_W-1:0]    tkt_cnt;

  logic [TW-1:0] tmr_count;
  logic          tmr_last;
  logic          tmr_load;
  logic          tmr_dec;
  logic          hold_end;

  logic seat_ok;
  logic grant_d;
  logic reject_d;
  logic tkt_d;
  logic timeout_d;

  assign seat_ok   = ({1'b0, seat_q} < NS) && !booked[seat_q];
  // A zero count in HOLD cannot occur; treating it as expiry keeps
  // the FSM from ever parking in HOLD.
  assign hold_end  = tmr_last || (tmr_count == '0);
  assign req_ready = (state == S_IDLE);

  hold_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .dec     (tmr_dec),
    .load_val(TW'(HOLD_CYCLES)),
    .count   (tmr_count),
    .last    (tmr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = seat_ok ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (cancel || pay_valid || hold_end)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d   = 1'b0;
    reject_d  = 1'b0;
    tkt_d     = 1'b0;
    timeout_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      S_CHECK: begin
        grant_d  = seat_ok;
        reject_d = !seat_ok;
        tmr_load = seat_ok;
      end
      S_HOLD: begin
        // cancel beats payment, payment on the last edge beats timeout
        if (cancel) begin
          tkt_d = 1'b0;
        end else if (pay_valid) begin
          tkt_d = 1'b1;
        end else if (hold_end) begin
          timeout_d = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seat_q       <= '0;
      booked       <= '0;
      tkt_cnt      <= '0;
      grant        <= 1'b0;
      reject       <= 1'b0;
      ticket_valid <= 1'b0;
      timeout      <= 1'b0;
      ticket_id    <= '0;
      seats_free   <= NS;
    end else begin
      grant        <= grant_d;
      reject       <= reject_d;
      ticket_valid <= tkt_d;
      timeout      <= timeout_d;
      if (state == S_IDLE && req_valid)
        seat_q <= req_seat;
      if (tkt_d) begin
        booked[seat_q] <= 1'b1;
        seats_free     <= seats_free - (SEAT_W + 1)'(1);
        ticket_id      <= tkt_cnt;
        tkt_cnt        <= tkt_cnt + TICKET_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_seat_server.sv
// Directed self-checking bench for bus_seat_server.
// NUM_SEATS=32, HOLD_CYCLES=16, TICKET_W=5.
module tb_bus_seat_server;

  localparam int SW = 6;
  localparam int TW = 5;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [SW-1:0] req_seat;
  logic          req_ready;
  logic          pay_valid;
  logic          cancel;
  logic          grant;
  logic          reject;
  logic          ticket_valid;
  logic [TW-1:0] ticket_id;
  logic          timeout;
  logic [SW:0]   seats_free;

  int tests;
  int fails;
  int exp_id;
  int exp_free;

  bus_seat_server #(
    .NUM_SEATS  (32),
    .SEAT_W     (SW),
    .HOLD_CYCLES(16),
    .TICKET_W   (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_seat    (req_seat),
    .req_ready   (req_ready),
    .pay_valid   (pay_valid),
    .cancel      (cancel),
    .grant       (grant),
    .reject      (reject),
    .ticket_valid(ticket_valid),
    .ticket_id   (ticket_id),
    .timeout     (timeout),
    .seats_free  (seats_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // E0 accept then E1 decision; returns after E1
  task automatic req(input int s);
    req_valid = 1'b1;
    req_seat  = SW'(s);
    tick();
    req_valid = 1'b0;
    chk("busy_after_e0", int'(req_ready), 0);
    tick();
  endtask

  task automatic book(input int s, input int id, input int nfree);
    req(s);
    chk("book_grant", int'(grant), 1);
    pay_valid = 1'b1;
    tick();
    pay_valid = 1'b0;
    chk("book_tv", int'(ticket_valid), 1);
    chk("book_id", int'(ticket_id), id);
    chk("book_free", int'(seats_free), nfree);
    tick();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_seat  = '0;
    pay_valid = 1'b0;
    cancel    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_grant", int'(grant), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_tv", int'(ticket_valid), 0);
    chk("rst_to", int'(timeout), 0);
    chk("rst_id", int'(ticket_id), 0);
    chk("rst_free", int'(seats_free), 32);
    chk("rst_ready", int'(req_ready), 1);

    // seat 5: grant at E1, pay at E2
    req(5);
    chk("s5_grant", int'(grant), 1);
    chk("s5_noreject", int'(reject), 0);
    pay_valid = 1'b1;
    tick();
    pay_valid = 1'b0;
    chk("s5_tv", int'(ticket_valid), 1);
    chk("s5_id", int'(ticket_id), 0);
    chk("s5_free", int'(seats_free), 31);
    chk("s5_ready", int'(req_ready), 1);
    chk("s5_grant_pulse", int'(grant), 0);
    tick();
    chk("s5_tv_pulse", int'(ticket_valid), 0);

    // rebook seat 5 -> reject
    req(5);
    chk("s5again_rej", int'(reject), 1);
    chk("s5again_grant", int'(grant), 0);
    chk("s5again_ready", int'(req_ready), 1);
    chk("s5again_free", int'(seats_free), 31);
    tick();
    chk("rej_pulse", int'(reject), 0);

    // out of range seat
    req(40);
    chk("s40_rej", int'(reject), 1);
    chk("s40_free", int'(seats_free), 31);
    tick();

    // payment ignored in IDLE
    pay_valid = 1'b1;
    tick();
    tick();
    pay_valid = 1'b0;
    chk("idle_pay_tv", int'(ticket_valid), 0);
    chk("idle_pay_free", int'(seats_free), 31);

    // seat 7 timeout: E2..E16 quiet, timeout after E17
    req(7);
    chk("s7_grant", int'(grant), 1);
    for (int i = 0; i < 15; i++) tick();
    chk("s7_to_early", int'(timeout), 0);
    chk("s7_still_hold", int'(req_ready), 0);
    tick();
    chk("s7_to", int'(timeout), 1);
    chk("s7_to_ready", int'(req_ready), 1);
    chk("s7_to_free", int'(seats_free), 31);
    tick();
    chk("s7_to_pulse", int'(timeout), 0);

    // seat 7 is still free; book it now (counter unchanged by reject)
    book(7, 1, 30);

    // seat 9: cancel and pay together -> cancel wins
    req(9);
    chk("s9_grant", int'(grant), 1);
    cancel    = 1'b1;
    pay_valid = 1'b1;
    tick();
    cancel    = 1'b0;
    pay_valid = 1'b0;
    chk("s9_cx_tv", int'(ticket_valid), 0);
    chk("s9_cx_to", int'(timeout), 0);
    chk("s9_cx_ready", int'(req_ready), 1);
    chk("s9_cx_free", int'(seats_free), 30);
    tick();

    // seat 9 again, pay on the final window edge E17
    req(9);
    chk("s9b_grant", int'(grant), 1);
    for (int i = 0; i < 15; i++) tick();
    pay_valid = 1'b1;
    tick();
    pay_valid = 1'b0;
    chk("s9b_tv", int'(ticket_valid), 1);
    chk("s9b_to", int'(timeout), 0);
    chk("s9b_id", int'(ticket_id), 2);
    chk("s9b_free", int'(seats_free), 29);
    tick();

    // fill the bus: remaining 29 seats take IDs 3..31
    exp_id   = 3;
    exp_free = 29;
    for (int s = 0; s < 32; s++) begin
      if (s != 5 && s != 7 && s != 9) begin
        exp_free--;
        book(s, exp_id, exp_free);
        exp_id = (exp_id + 1) % 32;
      end
    end
    chk("full_free", int'(seats_free), 0);
    chk("full_id", int'(ticket_id), 31);

    // 33rd attempt on a full bus
    req(12);
    chk("full_rej", int'(reject), 1);
    chk("full_free2", int'(seats_free), 0);
    tick();

    // counter restarts after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_free", int'(seats_free), 32);
    book(3, 0, 31);
    book(4, 1, 30);

    // reset mid-hold
    req(6);
    chk("s6_grant", int'(grant), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_free", int'(seats_free), 32);
    chk("midrst_id", int'(ticket_id), 0);
    chk("midrst_ready", int'(req_ready), 1);
    chk("midrst_tv", int'(ticket_valid), 0);

    // bookings cleared: seat 3 grants again
    req(3);
    chk("s3_after_rst", int'(grant), 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("s3_cx_ready", int'(req_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
